// File: rtl/acao_noite.sv
// Night-action collector for a werewolf game: gathers wolf/doctor targets, resolves the kill, publishes the result.
// Latency: target registration 1 cycle after confirma; result valid 2 cycles after the fim_noite edge.
// Backpressure: none; every input is a single-cycle pulse sampled on the rising edge, extra pulses are dropped.
module acao_noite #(
    parameter int N_JOG = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             novo_jogo,
    input  logic             inicia,
    input  logic [2:0]       jogador,
    input  logic [1:0]       classe,
    input  logic             seleciona,
    input  logic             confirma,
    input  logic             fim_noite,
    output logic [2:0]       alvo_atual,
    output logic             acao_registrada,
    output logic [2:0]       alvo_lobo,
    output logic [2:0]       alvo_medico,
    output logic             lobo_valido,
    output logic             medico_valido,
    output logic [2:0]       morto,
    output logic             houve_morte,
    output logic [N_JOG-1:0] vivos,
    output logic             pronto,
    output logic [1:0]       db_estado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        COLETA  = 2'd1,
        RESOLVE = 2'd2,
        PUBLICA = 2'd3
    } estado_t;

    localparam logic [2:0] NINGUEM     = 3'b111;
    localparam logic [1:0] CLASSE_LOBO = 2'b01;
    localparam logic [1:0] CLASSE_MED  = 2'b10;

    estado_t    estado;
    estado_t    prox_estado;
    logic [2:0] menor_vivo;
    logic [2:0] prox_vivo;
    logic [3:0] cand;
    logic       achou;
    logic       confirma_ok;
    logic       mata;

    // Lowest alive index; falls back to 0 when nobody is alive.
    always_comb begin
        menor_vivo = 3'd0;
        for (int i = N_JOG - 1; i >= 0; i--) begin
            if (vivos[i]) menor_vivo = 3'(i);
        end
    end

    // Next alive index strictly after alvo_atual, wrapping; unchanged if no other player is alive.
    always_comb begin
        prox_vivo = alvo_atual;
        achou     = 1'b0;
        cand      = 4'd0;
        for (int k = 1; k < N_JOG; k++) begin
            cand = {1'b0, alvo_atual} + 4'(k);
            if (cand >= 4'(N_JOG)) cand = cand - 4'(N_JOG);
            if (!achou && vivos[cand[2:0]]) begin
                prox_vivo = cand[2:0];
                achou     = 1'b1;
            end
        end
    end

    // Qualified confirm and the kill decision used in RESOLVE.
    always_comb begin
        confirma_ok = confirma && ({1'b0, jogador} < 4'(N_JOG));
        mata        = lobo_valido && vivos[alvo_lobo]
                      && !(medico_valido && (alvo_medico == alvo_lobo));
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    // Next-state logic: inicia restarts collection from any state.
    always_comb begin
        prox_estado = estado;
        if (inicia) begin
            prox_estado = COLETA;
        end else begin
            case (estado)
                COLETA:  if (fim_noite) prox_estado = RESOLVE;
                RESOLVE: prox_estado = PUBLICA;
                default: prox_estado = estado;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        db_estado = estado;
        pronto    = (estado == PUBLICA);
    end

    // Datapath: candidate target, registered actions, and night result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alvo_atual      <= 3'd0;
            acao_registrada <= 1'b0;
            alvo_lobo       <= 3'd0;
            alvo_medico     <= 3'd0;
            lobo_valido     <= 1'b0;
            medico_valido   <= 1'b0;
            morto           <= NINGUEM;
            houve_morte     <= 1'b0;
            vivos           <= '1;
        end else begin
            acao_registrada <= 1'b0;
            if (inicia) begin
                lobo_valido   <= 1'b0;
                medico_valido <= 1'b0;
                houve_morte   <= 1'b0;
                morto         <= NINGUEM;
                alvo_atual    <= menor_vivo;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (novo_jogo) vivos <= '1;
                    end
                    COLETA: begin
                        // fim_noite wins; confirm wins over select and uses the pre-increment target.
                        if (fim_noite) begin
                            acao_registrada <= 1'b0;
                        end else if (confirma_ok) begin
                            acao_registrada <= 1'b1;
                            alvo_atual      <= menor_vivo;
                            if (classe == CLASSE_LOBO && !lobo_valido) begin
                                alvo_lobo   <= alvo_atual;
                                lobo_valido <= 1'b1;
                            end else if (classe == CLASSE_MED && !medico_valido) begin
                                alvo_medico   <= alvo_atual;
                                medico_valido <= 1'b1;
                            end
                        end else if (seleciona) begin
                            alvo_atual <= prox_vivo;
                        end
                    end
                    RESOLVE: begin
                        if (mata) begin
                            morto            <= alvo_lobo;
                            houve_morte      <= 1'b1;
                            vivos[alvo_lobo] <= 1'b0;
                        end else begin
                            morto       <= NINGUEM;
                            houve_morte <= 1'b0;
                        end
                    end
                    default: begin
                        houve_morte <= houve_morte;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acao_noite.sv
// Testbench for acao_noite: directed night scenarios plus a randomized run against a list-based reference model.
// Latency: compares outputs 1 time unit after each rising edge.
// Backpressure: not applicable; all stimulus is single-cycle pulses.
module tb_acao_noite;
    localparam int N = 5;
    localparam int P_OCI = 0, P_COL = 1, P_RES = 2, P_PUB = 3;
    // {alvo_atual, acao, alvo_lobo, alvo_medico, lv, mv, morto, houve_morte, vivos, pronto, estado}
    localparam logic [23:0] RST_VEC = {3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, 5'b11111, 1'b0, 2'd0};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       novo_jogo = 1'b0, inicia = 1'b0, seleciona = 1'b0, confirma = 1'b0, fim_noite = 1'b0;
    logic [2:0] jogador = 3'd0;
    logic [1:0] classe = 2'd0;
    logic [2:0] alvo_atual, alvo_lobo, alvo_medico, morto;
    logic       acao_registrada, lobo_valido, medico_valido, houve_morte, pronto;
    logic [4:0] vivos;
    logic [1:0] db_estado;

    acao_noite #(.N_JOG(N)) dut (
        .clock(clock), .reset(reset), .novo_jogo(novo_jogo), .inicia(inicia),
        .jogador(jogador), .classe(classe), .seleciona(seleciona), .confirma(confirma),
        .fim_noite(fim_noite), .alvo_atual(alvo_atual), .acao_registrada(acao_registrada),
        .alvo_lobo(alvo_lobo), .alvo_medico(alvo_medico), .lobo_valido(lobo_valido),
        .medico_valido(medico_valido), .morto(morto), .houve_morte(houve_morte),
        .vivos(vivos), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int       m_phase, m_alvo, m_lobo, m_med, m_morto;
    bit       m_lv, m_mv, m_hm, m_acao;
    bit [4:0] m_vivos;

    function automatic logic [23:0] dut_vec();
        return {alvo_atual, acao_registrada, alvo_lobo, alvo_medico, lobo_valido, medico_valido,
                morto, houve_morte, vivos, pronto, db_estado};
    endfunction

    function automatic logic [23:0] model_vec();
        return {3'(m_alvo), m_acao, 3'(m_lobo), 3'(m_med), m_lv, m_mv, 3'(m_morto), m_hm,
                m_vivos, (m_phase == P_PUB), 2'(m_phase)};
    endfunction

    task automatic model_reset();
        m_phase = P_OCI; m_vivos = '1; m_alvo = 0; m_lobo = 0; m_med = 0;
        m_lv = 0; m_mv = 0; m_hm = 0; m_acao = 0; m_morto = 7;
    endtask

    function automatic int lowest_alive();
        int q[$];
        for (int i = 0; i < N; i++) if (m_vivos[i]) q.push_back(i);
        if (q.size() == 0) return 0;
        return q[0];
    endfunction

    function automatic int next_alive(int cur);
        int q[$];
        for (int i = 0; i < N; i++) if (m_vivos[i]) q.push_back(i);
        if (q.size() == 0) return cur;
        for (int k = 0; k < q.size(); k++) if (q[k] > cur) return q[k];
        return q[0];
    endfunction

    task automatic model_update(bit ini, bit nj, bit sel, bit conf, bit fim, int jog, int cls);
        m_acao = 0;
        if (ini) begin
            m_phase = P_COL; m_lv = 0; m_mv = 0; m_hm = 0; m_morto = 7; m_alvo = lowest_alive();
        end else if (m_phase == P_OCI) begin
            if (nj) m_vivos = '1;
        end else if (m_phase == P_COL) begin
            if (fim) m_phase = P_RES;
            else if (conf && jog < N) begin
                m_acao = 1;
                if (cls == 1 && !m_lv) begin m_lobo = m_alvo; m_lv = 1; end
                else if (cls == 2 && !m_mv) begin m_med = m_alvo; m_mv = 1; end
                m_alvo = lowest_alive();
            end else if (sel) m_alvo = next_alive(m_alvo);
        end else if (m_phase == P_RES) begin
            if (m_lv && m_vivos[m_lobo] && !(m_mv && m_med == m_lobo)) begin
                m_morto = m_lobo; m_hm = 1; m_vivos[m_lobo] = 0;
            end else begin
                m_morto = 7; m_hm = 0;
            end
            m_phase = P_PUB;
        end
    endtask

    // One clock of stimulus; model advances with the same inputs, outputs settle by return.
    task automatic step(bit ini, bit nj, bit sel, bit conf, bit fim, logic [2:0] jog, logic [1:0] cls);
        inicia = ini; novo_jogo = nj; seleciona = sel; confirma = conf; fim_noite = fim;
        jogador = jog; classe = cls;
        @(posedge clock);
        model_update(ini, nj, sel, conf, fim, int'(jog), int'(cls));
        #1;
        inicia = 0; novo_jogo = 0; seleciona = 0; confirma = 0; fim_noite = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #7;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_bad++; $display("FAIL reset_state: got %h expected %h", dut_vec(), RST_VEC);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_kill();
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd0 || db_estado !== 2'd1) begin
            n_bad++; $display("FAIL kill_start: got alvo=%0d st=%0d expected 0 1", alvo_atual, db_estado);
        end
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd0, 2'b01);
        n_cmp++;
        if (acao_registrada !== 1'b1 || alvo_lobo !== 3'd2 || lobo_valido !== 1'b1 || alvo_atual !== 3'd0) begin
            n_bad++; $display("FAIL kill_wolf: got acao=%0d lobo=%0d lv=%0d alvo=%0d expected 1 2 1 0",
                              acao_registrada, alvo_lobo, lobo_valido, alvo_atual);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd4) begin
            n_bad++; $display("FAIL kill_select: got %0d expected 4", alvo_atual);
        end
        step(0, 0, 1, 1, 0, 3'd1, 2'b10);   // select+confirm together
        n_cmp++;
        if (alvo_medico !== 3'd4 || medico_valido !== 1'b1 || alvo_atual !== 3'd0 || acao_registrada !== 1'b1) begin
            n_bad++; $display("FAIL kill_doctor_selconf: got med=%0d mv=%0d alvo=%0d acao=%0d expected 4 1 0 1",
                              alvo_medico, medico_valido, alvo_atual, acao_registrada);
        end
        step(0, 0, 0, 0, 1, 3'd0, 2'd0);
        n_cmp++;
        if (db_estado !== 2'd2 || pronto !== 1'b0) begin
            n_bad++; $display("FAIL kill_resolve: got st=%0d pronto=%0d expected 2 0", db_estado, pronto);
        end
        step(0, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (pronto !== 1'b1 || houve_morte !== 1'b1 || morto !== 3'd2 || vivos !== 5'b11011 || db_estado !== 2'd3) begin
            n_bad++; $display("FAIL kill_result: got pronto=%0d hm=%0d morto=%0d vivos=%b expected 1 1 2 11011",
                              pronto, houve_morte, morto, vivos);
        end
        step(0, 0, 1, 1, 1, 3'd0, 2'b01);   // ignored in PUBLICA
        n_cmp++;
        if (dut_vec() !== model_vec() || acao_registrada !== 1'b0 || morto !== 3'd2) begin
            n_bad++; $display("FAIL kill_hold: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_save();
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (pronto !== 1'b0 || morto !== 3'd7 || houve_morte !== 1'b0 || lobo_valido !== 1'b0) begin
            n_bad++; $display("FAIL save_inicia: got pronto=%0d morto=%0d hm=%0d lv=%0d expected 0 7 0 0",
                              pronto, morto, houve_morte, lobo_valido);
        end
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd3) begin
            n_bad++; $display("FAIL save_skip_dead: got %0d expected 3", alvo_atual);
        end
        step(0, 0, 0, 1, 0, 3'd3, 2'b01);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd4, 2'b10);
        step(0, 0, 0, 0, 1, 3'd0, 2'd0);
        step(0, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (pronto !== 1'b1 || houve_morte !== 1'b0 || morto !== 3'd7 || vivos !== 5'b11011
            || alvo_lobo !== 3'd3 || alvo_medico !== 3'd3) begin
            n_bad++; $display("FAIL save_result: got hm=%0d morto=%0d vivos=%b lobo=%0d med=%0d expected 0 7 11011 3 3",
                              houve_morte, morto, vivos, alvo_lobo, alvo_medico);
        end
    endtask

    task automatic test_skip();
        do_reset();
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd0, 2'b01);
        step(0, 0, 0, 0, 1, 3'd0, 2'd0);
        step(0, 0, 0, 0, 0, 3'd0, 2'd0);
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd1, 2'b01);
        step(0, 0, 0, 0, 1, 3'd0, 2'd0);
        step(0, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (vivos !== 5'b10110 || morto !== 3'd3) begin
            n_bad++; $display("FAIL skip_setup: got vivos=%b morto=%0d expected 10110 3", vivos, morto);
        end
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd1) begin
            n_bad++; $display("FAIL skip_lowest: got %0d expected 1", alvo_atual);
        end
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd2) begin
            n_bad++; $display("FAIL skip_sel1: got %0d expected 2", alvo_atual);
        end
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd4) begin
            n_bad++; $display("FAIL skip_sel2: got %0d expected 4", alvo_atual);
        end
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd1) begin
            n_bad++; $display("FAIL skip_wrap: got %0d expected 1", alvo_atual);
        end
    endtask

    task automatic test_second_wolf();
        do_reset();
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd0, 2'b01);
        n_cmp++;
        if (acao_registrada !== 1'b1 || alvo_lobo !== 3'd1) begin
            n_bad++; $display("FAIL wolf_first: got acao=%0d lobo=%0d expected 1 1", acao_registrada, alvo_lobo);
        end
        step(0, 0, 0, 1, 0, 3'd6, 2'b01);
        n_cmp++;
        if (acao_registrada !== 1'b0) begin
            n_bad++; $display("FAIL bad_player_ignored: got acao=%0d expected 0", acao_registrada);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (alvo_atual !== 3'd3) begin
            n_bad++; $display("FAIL wolf_sel3: got %0d expected 3", alvo_atual);
        end
        step(0, 0, 0, 1, 0, 3'd2, 2'b01);
        n_cmp++;
        if (acao_registrada !== 1'b1 || alvo_lobo !== 3'd1 || lobo_valido !== 1'b1 || alvo_atual !== 3'd0) begin
            n_bad++; $display("FAIL wolf_second: got acao=%0d lobo=%0d lv=%0d alvo=%0d expected 1 1 1 0",
                              acao_registrada, alvo_lobo, lobo_valido, alvo_atual);
        end
    endtask

    task automatic test_fim_priority();
        step(0, 0, 0, 1, 1, 3'd3, 2'b10);
        n_cmp++;
        if (acao_registrada !== 1'b0 || db_estado !== 2'd2 || medico_valido !== 1'b0) begin
            n_bad++; $display("FAIL fim_priority: got acao=%0d st=%0d mv=%0d expected 0 2 0",
                              acao_registrada, db_estado, medico_valido);
        end
        step(0, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (db_estado !== 2'd3 || morto !== 3'd1 || houve_morte !== 1'b1 || vivos !== 5'b11101) begin
            n_bad++; $display("FAIL fim_result: got st=%0d morto=%0d hm=%0d vivos=%b expected 3 1 1 11101",
                              db_estado, morto, houve_morte, vivos);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        step(0, 0, 1, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd0, 2'b01);
        reset = 1'b1;
        #2;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_bad++; $display("FAIL reset_mid_coleta: got %h expected %h", dut_vec(), RST_VEC);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step(1, 0, 0, 0, 0, 3'd0, 2'd0);
        step(0, 0, 0, 1, 0, 3'd0, 2'b01);
        step(0, 0, 0, 0, 1, 3'd0, 2'd0);
        reset = 1'b1;
        #2;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_bad++; $display("FAIL reset_mid_resolve: got %h expected %h", dut_vec(), RST_VEC);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0, 3'd0, 2'd0);
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_bad++; $display("FAIL reset_after_release: got %h expected %h", dut_vec(), RST_VEC);
        end
    endtask

    task automatic test_random();
        bit ini, nj, sel, conf, fim;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                ini  = ($urandom_range(0, 24) == 0);
                nj   = !ini && ($urandom_range(0, 3) == 0);
                sel  = ($urandom_range(0, 2) == 0);
                conf = ($urandom_range(0, 3) == 0);
                fim  = ($urandom_range(0, 11) == 0);
                step(ini, nj, sel, conf, fim, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL random_cycle_%0d: got %h expected %h", c, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_kill();
        test_save();
        test_skip();
        test_second_wolf();
        test_fim_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/acao_noite.md
ACAO_NOITE -- requirements
Module: acao_noite

Interface
REQ-001 Parameter N_JOG, default 5: number of players; player indices are 0..N_JOG-1.
REQ-002 clock  input  1  system clock, all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 novo_jogo  input  1  one-cycle pulse; honoured only in OCIOSO; sets vivos to all ones.
REQ-005 inicia  input  1  one-cycle pulse; starts collection for a new night.
REQ-006 jogador  input  3  index of the player currently acting.
REQ-007 classe  input  2  class of that player: 00 villager, 01 wolf, 10 doctor, 11 error.
REQ-008 seleciona  input  1  one-cycle pulse; advances the candidate target.
REQ-009 confirma  input  1  one-cycle pulse; commits the candidate target for the current player.
REQ-010 fim_noite  input  1  one-cycle pulse; closes the night and triggers resolution.
REQ-011 alvo_atual  output  3  candidate target index.
REQ-012 acao_registrada  output  1  one-cycle pulse when a confirma is accepted.
REQ-013 alvo_lobo, alvo_medico  output  3 each  registered wolf and doctor targets.
REQ-014 lobo_valido, medico_valido  output  1 each  set when the corresponding target is registered.
REQ-015 morto  output  3  index of the player killed this night; 3'b111 when nobody died.
REQ-016 houve_morte  output  1  a player was killed this night.
REQ-017 vivos  output  5  alive mask; bit i is player i.
REQ-018 pronto  output  1  night result valid.
REQ-019 db_estado  output  2  state encoding: OCIOSO=0, COLETA=1, RESOLVE=2, PUBLICA=3.

Function
REQ-020 The FSM SHALL have states OCIOSO, COLETA, RESOLVE and PUBLICA, registered on clock with asynchronous reset to OCIOSO.
REQ-021 inicia in any state SHALL, on the next edge:
- enter COLETA
- clear lobo_valido, medico_valido, houve_morte and pronto
- set morto to 3'b111
- load alvo_atual with the lowest alive index.
REQ-022 In COLETA, seleciona SHALL move alvo_atual to the next alive index above the current one, wrapping 4->0, skipping dead players; with exactly one player alive, alvo_atual SHALL be unchanged.
REQ-023 In COLETA, confirma with jogador<N_JOG SHALL:
- pulse acao_registrada for one cycle
- reload alvo_atual with the lowest alive index.
REQ-024 The same confirma SHALL also register the target:
- classe 01 and lobo_valido=0: alvo_lobo<=alvo_atual and lobo_valido<=1
- classe 10 and medico_valido=0: alvo_medico<=alvo_atual and medico_valido<=1
- any other class, or a second confirm by the same class: nothing is registered.
REQ-025 confirma with jogador>=N_JOG, or in any state other than COLETA, SHALL be ignored (no pulse).
REQ-026 seleciona and confirma asserted together SHALL act as confirma alone, using the pre-increment alvo_atual.
REQ-027 fim_noite in COLETA SHALL move to RESOLVE and take priority over a simultaneous confirma or seleciona, which are dropped; fim_noite outside COLETA SHALL be ignored.
REQ-028 RESOLVE SHALL last exactly one cycle.
- A kill happens when lobo_valido=1, vivos[alvo_lobo]=1, and either medico_valido=0 or alvo_medico!=alvo_lobo.
- On a kill: morto<=alvo_lobo, houve_morte<=1, vivos[alvo_lobo]<=0.
- With no kill: morto<=3'b111, houve_morte<=0.
- The FSM then enters PUBLICA.
REQ-029 In PUBLICA, pronto SHALL be 1 and morto, houve_morte and vivos SHALL hold until inicia or reset; result outputs are therefore valid 2 cycles after the fim_noite edge.
REQ-030 A wolf targeting itself SHALL be treated as a normal target.

Reset
REQ-031 On reset SHALL:
- state=OCIOSO, vivos=5'b11111
- alvo_atual=alvo_lobo=alvo_medico=0
- lobo_valido=medico_valido=houve_morte=pronto=acao_registrada=0
- morto=3'b111.
REQ-032 Reset asserted mid-COLETA or mid-RESOLVE SHALL discard all registered actions with no partial update to vivos.

Verification
REQ-033 Wolf picks target 2, doctor picks target 4, fim_noite -> after 2 cycles: pronto=1, houve_morte=1, morto=2, vivos=5'b11011.
REQ-034 Wolf and doctor both pick target 3 -> houve_morte=0, morto=3'b111, vivos unchanged.
REQ-035 vivos=5'b10110 (players 1, 2, 4 alive), inicia then 3 seleciona pulses -> alvo_atual sequence 1, 2, 4, 1.
REQ-036 Wolf confirms 1, then a second wolf confirm with alvo_atual=3 -> both acao_registrada pulses occur, alvo_lobo stays 1.
REQ-037 confirma and fim_noite in the same cycle -> no acao_registrada pulse, FSM enters RESOLVE.
REQ-038 Reset pulse during COLETA after a wolf confirm -> all outputs return to REQ-031 values.
